frame_seq_ctrl: RTL and testbench
=================================

FRAME_SEQ_CTRL -- requirements
Module: frame_seq_ctrl

Interface
REQ-001 SHALL have parameter H_DISP, default 320, meaning active pixels per line.
REQ-002 SHALL have parameter V_DISP, default 240, meaning active lines per frame.
REQ-003 SHALL have parameter WIDTH, default 400, meaning total clocks per line including blanking.
REQ-004 SHALL have parameter HEIGHT, default 300, meaning total lines per frame including blanking.
REQ-005 SHALL have parameter ADDR_W, default 26, meaning pixel-store address width.
REQ-006 SHALL have parameter MAX_ADDR, default 46233599, meaning last valid pixel-store address.
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port start, input, 1, run-request pulse.
REQ-010 SHALL have port stop_req, input, 1, finish-current-frame-then-halt request.
REQ-011 SHALL have port n_frames, input, 16, frame count; 0 means run until stop_req.
REQ-012 SHALL have port h_count, output, $clog2(WIDTH+1), horizontal raster position.
REQ-013 SHALL have port v_count, output, $clog2(HEIGHT+1), vertical raster position.
REQ-014 SHALL have port sync_flag, output, 1, high in blanking (h_count>=H_DISP or v_count>=V_DISP) or when not running.
REQ-015 SHALL have port rd_en, output, 1, pixel-store read strobe.
REQ-016 SHALL have port rd_addr, output, ADDR_W, pixel-store read address.
REQ-017 SHALL have port pix_valid, output, 1, pixel-store data valid (rd_en delayed one clock).
REQ-018 SHALL have ports frame_start (1, pulse), frame_idx (16, frames started), busy (1) and done (1, pulse), all outputs.

Function
REQ-019 SHALL implement FSM IDLE, RUN, STOPPING.
REQ-020 SHALL, in IDLE, hold h_count=0, v_count=0, sync_flag=1, rd_en=0, busy=0.
REQ-021 SHALL, in IDLE with start=1, latch n_frames, clear frame_idx and enter RUN next clock; frame_start SHALL pulse in the first RUN cycle.
REQ-022 SHALL, in RUN/STOPPING, increment h_count each clock; at WIDTH-1 wrap to 0 and increment v_count; at v_count HEIGHT-1 together with h_count WIDTH-1, wrap both to 0 (frame end).
REQ-023 SHALL assert rd_en = busy and not sync_flag, combinationally from registered counters.
REQ-024 SHALL, after each rd_en cycle, increment rd_addr by 1; at MAX_ADDR it SHALL wrap to 0.
REQ-025 SHALL hold rd_addr across blanking and across IDLE; rd_addr resets only on rst.
REQ-026 SHALL pulse frame_start and increment frame_idx on the cycle after each frame end when another frame follows.
REQ-027 SHALL, on frame end with latched n_frames!=0 and frame_idx==n_frames, go to IDLE and pulse done for one clock.
REQ-028 SHALL, on stop_req in RUN, enter STOPPING; at frame end in STOPPING it SHALL go to IDLE and pulse done.
REQ-029 SHALL ignore start outside IDLE and stop_req outside RUN.
REQ-030 SHALL, when stop_req coincides with frame end in RUN, finish immediately (IDLE, done) rather than run another frame.
REQ-031 SHALL, when n_frames-limit and stop_req coincide, pulse done exactly once.

Reset
REQ-032 SHALL, on rst low, asynchronously force IDLE, h_count=0, v_count=0, rd_addr=0, frame_idx=0, sync_flag=1, rd_en=0, pix_valid=0, frame_start=0, busy=0, done=0.
REQ-033 SHALL, on rst low mid-frame, abandon the frame without a done pulse.

Structure
REQ-034 SHALL place the FSM state enum and default raster constants (320/240/400/300, ADDR_W, MAX_ADDR) in shared package frame_seq_pkg.
REQ-035 SHALL instantiate one sub-module raster_counter (h/v counters with enable and frame-end output).

Verification
REQ-036 SHALL cover: start with n_frames=1 -> exactly 76800 rd_en cycles, rd_addr 0->76800, done one clock after the clock with h_count=399, v_count=299.
REQ-037 SHALL cover: n_frames=3 -> frame_start pulses 3 times 120000 clocks apart, frame_idx ends at 3, rd_addr=230400.
REQ-038 SHALL cover: n_frames=0, stop_req at v_count=100 -> frame completes, done at frame end, busy low after.
REQ-039 SHALL cover: rd_addr preset near wrap (MAX_ADDR=76799 override), 2 frames -> rd_addr 76799 followed by 0, second frame restarts at 0.
REQ-040 SHALL cover: rst low at h_count=50, v_count=10 -> all outputs at reset values immediately, no done pulse.
REQ-041 SHALL cover: pix_valid equals rd_en delayed one clock over a full frame, and sync_flag==~rd_en while busy.

Source files
------------

// File: rtl/frame_seq_pkg.sv
// Shared types and default raster geometry for the frame sequencer.
package frame_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int          DEF_H_DISP   = 320;
    localparam int          DEF_V_DISP   = 240;
    localparam int          DEF_WIDTH    = 400;
    localparam int          DEF_HEIGHT   = 300;
    localparam int          DEF_ADDR_W   = 26;
    localparam int unsigned DEF_MAX_ADDR = 46233599;

endpackage

// File: rtl/raster_counter.sv
// Horizontal/vertical raster position counters; frame_end flags the last clock of a frame.
module raster_counter #(
    parameter int WIDTH  = 400,
    parameter int HEIGHT = 300,
    parameter int HW     = $clog2(WIDTH + 1),
    parameter int VW     = $clog2(HEIGHT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [HW-1:0] h_count,
    output logic [VW-1:0] v_count,
    output logic          frame_end
);

    logic h_last;
    logic v_last;

    assign h_last    = (h_count == HW'(WIDTH - 1));
    assign v_last    = (v_count == VW'(HEIGHT - 1));
    assign frame_end = en && h_last && v_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_count <= '0;
            v_count <= '0;
        end else if (en) begin
            if (h_last) begin
                h_count <= '0;
                v_count <= v_last ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: runs N frames (or until stopped) of raster scan, issuing pixel-store reads.
module frame_seq_ctrl
    import frame_seq_pkg::*;
#(
    parameter int          H_DISP   = DEF_H_DISP,
    parameter int          V_DISP   = DEF_V_DISP,
    parameter int          WIDTH    = DEF_WIDTH,
    parameter int          HEIGHT   = DEF_HEIGHT,
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int unsigned MAX_ADDR = DEF_MAX_ADDR
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            stop_req,
    input  logic [15:0]                     n_frames,
    output logic [$clog2(WIDTH + 1)-1:0]    h_count,
    output logic [$clog2(HEIGHT + 1)-1:0]   v_count,
    output logic                            sync_flag,
    output logic                            rd_en,
    output logic [ADDR_W-1:0]               rd_addr,
    output logic                            pix_valid,
    output logic                            frame_start,
    output logic [15:0]                     frame_idx,
    output logic                            busy,
    output logic                            done
);

    localparam int HW = $clog2(WIDTH + 1);
    localparam int VW = $clog2(HEIGHT + 1);

    state_t      state, state_nxt;
    logic [15:0] n_lat;
    logic        frame_end;
    logic        latch;
    logic        fs_nxt;
    logic        done_nxt;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .HW     (HW),
        .VW     (VW)
    ) u_raster (
        .clk       (clk),
        .rst       (rst),
        .en        (busy),
        .h_count   (h_count),
        .v_count   (v_count),
        .frame_end (frame_end)
    );

    assign busy      = (state != IDLE);
    assign sync_flag = !busy || (h_count >= HW'(H_DISP)) || (v_count >= VW'(V_DISP));
    assign rd_en     = busy && !sync_flag;

    // A stop request landing on the frame-end clock finishes now instead of detouring via STOPPING.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        fs_nxt    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    latch     = 1'b1;
                    fs_nxt    = 1'b1;
                end
            end
            RUN: begin
                if (frame_end) begin
                    if (stop_req || (n_lat != 16'd0 && frame_idx == n_lat)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        fs_nxt = 1'b1;
                    end
                end else if (stop_req) begin
                    state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                if (frame_end) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            n_lat       <= '0;
            frame_idx   <= '0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            frame_start <= fs_nxt;
            done        <= done_nxt;
            if (latch) n_lat <= n_frames;
            // frame_idx counts frames started, so the first frame reads as 1.
            if (latch)       frame_idx <= 16'd1;
            else if (fs_nxt) frame_idx <= frame_idx + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr   <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= rd_en;
            if (rd_en) rd_addr <= (rd_addr == ADDR_W'(MAX_ADDR)) ? '0 : rd_addr + 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Scoreboard bench for frame_seq_ctrl on a shrunken raster (12x9 total, 8x6 active).
module tb_frame_seq_ctrl;

    localparam int HD = 8, VD = 6, W = 12, H = 9, AW = 8, MA = 95;
    localparam int F = W * H, PIX = HD * VD;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, stop_req = 1'b0;
    logic [15:0]   n_frames = '0;
    logic [3:0]    h_count, v_count;
    logic          sync_flag, rd_en, pix_valid, frame_start, busy, done;
    logic [AW-1:0] rd_addr;
    logic [15:0]   frame_idx;

    frame_seq_ctrl #(
        .H_DISP(HD), .V_DISP(VD), .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .MAX_ADDR(MA)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop_req(stop_req), .n_frames(n_frames),
        .h_count(h_count), .v_count(v_count), .sync_flag(sync_flag), .rd_en(rd_en),
        .rd_addr(rd_addr), .pix_valid(pix_valid), .frame_start(frame_start),
        .frame_idx(frame_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int cyc;
        int idx;
        int addr;
    } ev_t;

    ev_t expq[$];
    ev_t e;
    int  n_vec = 0, n_err = 0, cyc = 0, base = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle invariants plus scoreboard pop on every frame_start/done.
    bit prev_rd = 0, in_frame = 0;
    int prev_addr = 0, rd_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_rd = 0; prev_addr = 0; rd_cnt = 0; in_frame = 0;
        end else begin
            chk("pix_valid_delay", pix_valid, prev_rd);
            chk("rd_addr_step", rd_addr, prev_rd ? ((prev_addr == MA) ? 0 : prev_addr + 1) : prev_addr);
            if (busy) chk("sync_vs_rd_en", sync_flag, !rd_en);
            else begin
                chk("idle_h", h_count, 0);
                chk("idle_v", v_count, 0);
                chk("idle_sync", sync_flag, 1);
                chk("idle_rd_en", rd_en, 0);
            end
            if (frame_start || done) begin
                if (in_frame) chk("rd_en_per_frame", rd_cnt, PIX);
                if (expq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_event: fs=%0d done=%0d at cycle %0d, none expected",
                             frame_start, done, cyc);
                end else begin
                    e = expq.pop_front();
                    chk("event_kind_done", done, e.is_done);
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_frame_idx", frame_idx, e.idx);
                    chk("event_rd_addr", rd_addr, e.addr);
                    if (done) chk("busy_at_done", busy, 0);
                end
                in_frame = frame_start;
                rd_cnt   = rd_en ? 1 : 0;
            end else if (rd_en) rd_cnt++;
            prev_rd = rd_en; prev_addr = rd_addr;
        end
    end

    task automatic check_reset_vals();
        chk("rst_h", h_count, 0);      chk("rst_v", v_count, 0);
        chk("rst_rd_addr", rd_addr, 0); chk("rst_frame_idx", frame_idx, 0);
        chk("rst_sync", sync_flag, 1); chk("rst_rd_en", rd_en, 0);
        chk("rst_pix_valid", pix_valid, 0); chk("rst_frame_start", frame_start, 0);
        chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst = 1'b0;
        #1 check_reset_vals();
        @(negedge clk); @(negedge clk); #2 rst = 1'b1;
        base = 0;
    endtask

    // Pushes expected events, then pulses start; returns in the first RUN cycle.
    task automatic run(input int nf, input int frames, input bit with_done);
        int t0;
        @(negedge clk);
        t0 = cyc;
        for (int k = 0; k < frames; k++)
            expq.push_back('{1'b0, t0 + 1 + k * F, k + 1, (base + k * PIX) % (MA + 1)});
        if (with_done) begin
            expq.push_back('{1'b1, t0 + 1 + frames * F, frames, (base + frames * PIX) % (MA + 1)});
            base = (base + frames * PIX) % (MA + 1);
        end
        n_frames = 16'(nf); start = 1'b1;
        @(negedge clk);
        start = 1'b0; n_frames = 16'd7;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin @(negedge clk); n++; end
        if (busy) begin
            n_vec++; n_err++;
            $display("FAIL wait_idle_timeout: busy still 1 after %0d cycles", limit);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_pos(input int hh, input int vv, input int limit);
        int n = 0;
        while (!(h_count == 4'(hh) && v_count == 4'(vv)) && n < limit) begin @(negedge clk); n++; end
        if (n >= limit) begin
            n_vec++; n_err++;
            $display("FAIL wait_pos_timeout: h=%0d v=%0d never reached (need %0d,%0d)", h_count, v_count, hh, vv);
        end
    endtask

    initial begin
        #2 check_reset_vals();
        @(negedge clk); #2 rst = 1'b1;

        run(1, 1, 1); wait_idle(2 * F);             // single frame
        run(3, 3, 1); wait_idle(4 * F);             // three frames, addr wraps inside
        do_reset();
        run(2, 2, 1); wait_idle(3 * F);             // 95 -> 0 wrap exactly at frame 2 end
        run(0, 1, 1); wait_pos(0, 4, F);            // stop mid-frame, unbounded run
        stop_req = 1'b1; @(negedge clk); stop_req = 1'b0;
        wait_idle(2 * F);
        run(0, 1, 1); wait_pos(W - 1, H - 1, F);    // stop on frame-end clock
        stop_req = 1'b1; @(negedge clk); stop_req = 1'b0;
        wait_idle(2 * F);
        run(1, 1, 1); wait_pos(W - 1, H - 1, F);    // stop coincides with frame limit
        stop_req = 1'b1; @(negedge clk); stop_req = 1'b0;
        wait_idle(2 * F);
        run(2, 2, 1); repeat (30) @(negedge clk);   // start ignored while running
        start = 1'b1; n_frames = 16'd1; @(negedge clk); start = 1'b0;
        wait_idle(3 * F);
        stop_req = 1'b1; @(negedge clk); stop_req = 1'b0;   // stop ignored in IDLE
        repeat (2) @(negedge clk);
        chk("stop_in_idle_busy", busy, 0);

        run(0, 1, 0); wait_pos(5, 1, F);            // reset mid-frame
        #2 rst = 1'b0;
        #1 check_reset_vals();
        @(negedge clk); @(negedge clk); #2 rst = 1'b1;
        repeat (F + 5) @(negedge clk);
        chk("no_pending_events", expq.size(), 0);
        chk("idle_after_abort", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
